// File: rtl/div_seq_n_if.sv
// Start/busy/done handshake bundle for div_seq_n.
// The dz flag exists only when DIV_ZERO_FLAG_EN is defined.
interface div_seq_n_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic             dz;

  modport master (
    output start, sign_mode, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, sign_mode, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
`else
  modport master (
    output start, sign_mode, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, sign_mode, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface

// File: rtl/div_seq_n.sv
// Restoring sequential divider, one quotient bit per clock, signed/unsigned.
// Define DIV_ZERO_FLAG_EN to add the dz flag and a 1-cycle divide-by-zero path.
//
// state | meaning
// IDLE  | waiting for start, operands captured on the start edge
// ITER  | one restoring step per clock, WIDTH steps
// FIX   | apply result signs (or divide-by-zero values), pulse done
module div_seq_n #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        clr,
  div_seq_n_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;
  logic             done_r;

  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;

  assign dvd_neg  = bus.sign_mode & bus.dividend[WIDTH-1];
  assign dvs_neg  = bus.sign_mode & bus.divisor[WIDTH-1];
  assign dvs_zero = (bus.divisor == '0);

  // Partial remainder stays below the divisor, so the top bit of trial is a clean sign.
  assign r_shift = {r_mag, q_mag[WIDTH-1]};
  assign trial   = r_shift - {2'b00, d_mag};

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef DIV_ZERO_FLAG_EN
          state_nxt = dvs_zero ? FIX : ITER;
`else
          state_nxt = ITER;
`endif
        end
      end
      ITER: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz_r;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt      <= '0;
      r_mag    <= '0;
      q_mag    <= '0;
      d_mag    <= '0;
      dvd_raw  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      done_r   <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dz_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_mag    <= dvd_neg ? -bus.dividend : bus.dividend;
            d_mag    <= dvs_neg ? -bus.divisor : bus.divisor;
            dvd_raw  <= bus.dividend;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            zero_div <= dvs_zero;
            cnt      <= '0;
            r_mag    <= '0;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH+1]) begin
            r_mag <= trial[WIDTH:0];
            q_mag <= {q_mag[WIDTH-2:0], 1'b1};
          end else begin
            r_mag <= r_shift[WIDTH:0];
            q_mag <= {q_mag[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done_r <= 1'b1;
          if (zero_div) begin
            quot_r <= '1;
            rem_r  <= dvd_raw;
          end else begin
            quot_r <= neg_q ? -q_mag : q_mag;
            rem_r  <= neg_r ? -r_mag[WIDTH-1:0] : r_mag[WIDTH-1:0];
          end
`ifdef DIV_ZERO_FLAG_EN
          dz_r <= zero_div;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.dz        = dz_r;
`endif

endmodule

// File: tb/tb_div_seq_n.sv
// Self-checking bench for div_seq_n at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_div_seq_n;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  div_seq_n_if #(.WIDTH(32)) b32 ();
  div_seq_n_if #(.WIDTH(8))  b8 ();

  div_seq_n #(.WIDTH(32)) dut32 (.clk(clk), .clr(clr), .bus(b32.slave));
  div_seq_n #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(b8.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with C-style truncation, masked to w bits.
  function automatic void ref_div(input int w, input bit sm, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r);
    longint unsigned mask;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    if ((64'(b) & mask) == 0) begin
      q = 32'(mask);
      r = 32'(64'(a) & mask);
      return;
    end
    sa = longint'(64'(a) & mask);
    sb = longint'(64'(b) & mask);
    if (sm) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    q = 32'(64'(sa / sb) & mask);
    r = 32'(64'(sa % sb) & mask);
  endfunction

  function automatic int exp_lat(input int w, input logic [31:0] b);
    logic [31:0] bm;
    bm = (w == 32) ? b : {24'b0, b[7:0]};
`ifdef DIV_ZERO_FLAG_EN
    if (bm == 0) return 1;
`endif
    return w + 1;
  endfunction

  task automatic set_in(input int w, input bit st, input bit sm, input logic [31:0] a,
                        input logic [31:0] b);
    if (w == 32) begin
      b32.start = st; b32.sign_mode = sm; b32.dividend = a; b32.divisor = b;
    end else begin
      b8.start = st; b8.sign_mode = sm; b8.dividend = a[7:0]; b8.divisor = b[7:0];
    end
  endtask

  task automatic get_out(input int w, output logic dn, output logic bs, output logic [31:0] q,
                         output logic [31:0] r, output logic dzv);
    dzv = 1'b0;
    if (w == 32) begin
      dn = b32.done; bs = b32.busy; q = b32.quotient; r = b32.remainder;
`ifdef DIV_ZERO_FLAG_EN
      dzv = b32.dz;
`endif
    end else begin
      dn = b8.done; bs = b8.busy; q = {24'b0, b8.quotient}; r = {24'b0, b8.remainder};
`ifdef DIV_ZERO_FLAG_EN
      dzv = b8.dz;
`endif
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic run_op(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input string tag);
    logic [31:0] eq, er, q, r;
    logic dn, bs, dzv;
    int lat, busy_cnt, el;
    ref_div(w, sm, a, b, eq, er);
    el = exp_lat(w, b);
    set_in(w, 1'b1, sm, a, b);
    @(negedge clk);
    lat = 0;
    busy_cnt = 0;
    get_out(w, dn, bs, q, r, dzv);
    while (!dn && lat < 2 * w + 10) begin
      if (bs) busy_cnt++;
      set_in(w, lat == poke_at, 1'($urandom), $urandom, $urandom);
      @(negedge clk);
      lat++;
      get_out(w, dn, bs, q, r, dzv);
    end
    set_in(w, 1'b0, 1'($urandom), $urandom, $urandom);
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_busycnt"}, 64'(busy_cnt), 64'(el));
    chk({tag, "_busy_at_done"}, 64'(bs), 64'd0);
    chk({tag, "_q"}, 64'(q), 64'(eq));
    chk({tag, "_r"}, 64'(r), 64'(er));
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, "_dz"}, 64'(dzv), (w == 32 ? b == 0 : b[7:0] == 0) ? 64'd1 : 64'd0);
`endif
  endtask

  initial begin
    logic dn, bs, dzv;
    logic [31:0] q, r, eq, er, a, b;
    int dcount, w;
    bit sm;

    clr = 1'b1;
    set_in(32, 1'b0, 1'b0, '0, '0);
    set_in(8, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    get_out(32, dn, bs, q, r, dzv);
    chk("rst_busy", 64'(bs), 64'd0);
    chk("rst_done", 64'(dn), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_dz", 64'(dzv), 64'd0);

    // clr and start on the same edge: clr wins
    set_in(32, 1'b1, 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    get_out(32, dn, bs, q, r, dzv);
    chk("clr_vs_start_busy", 64'(bs), 64'd0);
    set_in(32, 1'b0, 1'b0, '0, '0);
    clr = 1'b0;
    @(negedge clk);

    run_op(32, 1'b0, 32'd100, 32'd7, -1, "u100_7");
    ref_div(32, 1'b0, 32'd100, 32'd7, eq, er);
    @(negedge clk);
    get_out(32, dn, bs, q, r, dzv);
    chk("done_pulse", 64'(dn), 64'd0);
    chk("q_hold", 64'(q), 64'(eq));

    run_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, "s_m7_2");
    run_op(32, 1'b1, 32'd7, 32'hFFFF_FFFE, -1, "s_7_m2");
    run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "s_min_m1");
    run_op(32, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, "u_min_m1");
    run_op(32, 1'b0, 32'h1234, 32'd0, -1, "dz_u");
    run_op(32, 1'b1, 32'h1234, 32'd0, -1, "dz_s");

    @(negedge clk);
    run_op(32, 1'b0, 32'd100, 32'd7, 10, "poke_start");

    // clr at cycle 20 of a division discards it
    @(negedge clk);
    set_in(32, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd13);
    @(negedge clk);
    set_in(32, 1'b0, 1'b0, '0, '0);
    repeat (19) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    get_out(32, dn, bs, q, r, dzv);
    chk("clr_busy", 64'(bs), 64'd0);
    chk("clr_done", 64'(dn), 64'd0);
    chk("clr_q", 64'(q), 64'd0);
    chk("clr_r", 64'(r), 64'd0);
    chk("clr_dz", 64'(dzv), 64'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      get_out(32, dn, bs, q, r, dzv);
      if (dn || bs) dcount++;
    end
    chk("clr_no_done", 64'(dcount), 64'd0);
    run_op(32, 1'b0, 32'hDEAD_BEEF, 32'd13, -1, "after_clr");

    @(negedge clk);
    run_op(8, 1'b0, 32'hC8, 32'd3, -1, "w8_u_c8_3");
    run_op(8, 1'b1, 32'hC8, 32'd3, -1, "w8_s_c8_3");
    run_op(8, 1'b1, 32'h80, 32'hFF, -1, "w8_s_min_m1");
    run_op(8, 1'b0, 32'h5A, 32'd0, -1, "w8_dz");

    for (int i = 0; i < 24; i++) begin
      w = (i % 2 == 0) ? 32 : 8;
      sm = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 5);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (w == 8 && b[7:0] == 0 && b != 0) b = b | 32'd1;
      if (i % 3 == 0) @(negedge clk);
      run_op(w, sm, a, b, (i % 4 == 1) ? 3 : -1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
